// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants and the queue entry layout.
// The reset PC and the NOP word are also used by the fetch unit.
package fetch_queue_pkg;

  localparam logic [31:0] INIT_PC   = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch pushes {pc, instr}, decode pops the head.
// The queue takes the slave view; the fetch/decode side takes the master view.
interface fetch_queue_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        flush;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/fetchq_mem.sv
// Queue storage: DEPTH x {pc, instr}, synchronous write, asynchronous read.
// Contents are deliberately not reset; the occupancy count masks stale entries.
module fetchq_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  fq_entry_t             wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output fq_entry_t             rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush-on-redirect.
// Define FETCHQ_BYPASS_EN to let an empty queue pass the incoming pair straight to decode.
module fetch_queue #(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [31:0] INIT_PC    = fetch_queue_pkg::INIT_PC
) (
  input  logic                clk,
  input  logic                reset,
  fetch_queue_if.slave        q,
  output logic [DEPTH_LOG2:0] count
);

  import fetch_queue_pkg::*;

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic      empty, full;
  logic      push, pop;
  logic      mem_we;
  fq_entry_t head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // in_ready looks only at registered occupancy, so a pop never frees a slot the same cycle.
  assign q.in_ready = !full;
  assign pop        = !empty && q.out_ready;

`ifdef FETCHQ_BYPASS_EN
  logic bypass_take;

  // An empty queue forwards the incoming pair; if decode takes it, it is never stored.
  assign bypass_take = empty && q.in_valid && q.out_ready;
  assign push        = q.in_valid && q.in_ready && !bypass_take;
  assign q.out_valid = !empty || q.in_valid;

  always_comb begin
    q.out_pc    = INIT_PC;
    q.out_instr = NOP_INSTR;
    if (!empty) begin
      q.out_pc    = head.pc;
      q.out_instr = head.instr;
    end else if (q.in_valid) begin
      q.out_pc    = q.in_pc;
      q.out_instr = q.in_instr;
    end
  end
`else
  assign push        = q.in_valid && q.in_ready;
  assign q.out_valid = !empty;

  // An empty queue presents a NOP at the reset PC rather than whatever the array holds.
  always_comb begin
    q.out_pc    = INIT_PC;
    q.out_instr = NOP_INSTR;
    if (!empty) begin
      q.out_pc    = head.pc;
      q.out_instr = head.instr;
    end
  end
`endif

  assign mem_we = push && !q.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetchq_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata ('{pc: q.in_pc, instr: q.in_instr}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign count = count_q;

endmodule
